// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the instruction/data memory port
//            arbiter: FSM state encoding, timeout read-data pattern and the
//            default parameter values used by mem_port_arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_MAX_D_STREAK = 4;
   localparam int DEF_TIMEOUT_CYC  = 64;

   // Returned on the requester's read-data bus when the memory never answers.
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_sat_counter
// Purpose  : Up-counter with synchronous clear that stops at MAX_VAL.
//            Clear has priority over increment.
// Ports    : clk      - clock (rising edge)
//            rst      - asynchronous reset, active low
//            i_clr    - synchronous clear
//            i_inc    - increment request
//            o_count  - current count value
// Revision : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != c_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a data port onto one
//            shared memory port, one transfer in flight at a time. Data wins
//            by default; a fetch is forced through after MAX_D_STREAK
//            consecutive data grants taken while it was waiting. A transfer
//            with no m_ack for TIMEOUT_CYC cycles completes with
//            TIMEOUT_RDATA and sets a sticky error flag.
// Ports    : clk, rst (async, active low)
//            if_req/if_addr -> if_rdata/if_ack      fetch port
//            d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack   data port
//            m_req/m_we/m_addr/m_wdata <- m_rdata/m_ack   shared memory
//            stall_out   - pipeline stall while any request is unanswered
//            timeout_err - sticky abort flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack,
   output logic              stall_out,
   output logic              timeout_err
);

   localparam int c_STREAK_W = $clog2(MAX_D_STREAK + 1);
   localparam int c_TMO_W    = $clog2(TIMEOUT_CYC + 1);

   localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);
   // Count value seen during the last permitted BUSY cycle.
   localparam logic [c_TMO_W-1:0]    c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [DATA_W-1:0]     c_TMO_RDATA  = DATA_W'(TIMEOUT_RDATA);

   arb_state_t r_state;
   arb_state_t w_state_nxt;

   logic                  r_grant_d;      // transfer in flight belongs to data port
   logic                  r_m_we;
   logic [ADDR_W-1:0]     r_m_addr;
   logic [DATA_W-1:0]     r_m_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_timeout_err;

   logic                  w_busy;
   logic                  w_grant_i;
   logic                  w_grant_d;
   logic                  w_mem_done;
   logic                  w_timeout;
   logic [c_STREAK_W-1:0] w_streak;
   logic [c_TMO_W-1:0]    w_tmo_cnt;

   assign w_busy = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

   // ------------------------------------------------------------------------
   // Next-state and grant decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_mem_done  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_req && (!d_req || (w_streak == c_STREAK_MAX))) begin
               w_grant_i   = 1'b1;
               w_state_nxt = ST_BUSY_I;
            end else if (d_req) begin
               w_grant_d   = 1'b1;
               w_state_nxt = ST_BUSY_D;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (m_ack) begin
               w_mem_done  = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (w_tmo_cnt == c_TMO_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_grant_d     <= 1'b0;
         r_m_we        <= 1'b0;
         r_m_addr      <= '0;
         r_m_wdata     <= '0;
         r_rdata       <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_i || w_grant_d) begin
            r_grant_d <= w_grant_d;
            r_m_we    <= w_grant_d & d_we;
            r_m_addr  <= w_grant_d ? d_addr : if_addr;
            r_m_wdata <= w_grant_d ? d_wdata : '0;
         end
         if (w_mem_done) begin
            r_rdata <= m_rdata;
         end else if (w_timeout) begin
            r_rdata       <= c_TMO_RDATA;
            r_timeout_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Counters: data-grant streak (only grows while a fetch is waiting) and
   // BUSY-cycle timeout (restarted at every grant).
   // ------------------------------------------------------------------------
   arb_sat_counter #(
      .WIDTH   (c_STREAK_W),
      .MAX_VAL (MAX_D_STREAK)
   ) u_streak (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_grant_i | (w_grant_d & ~if_req)),
      .i_inc   (w_grant_d & if_req),
      .o_count (w_streak)
   );

   arb_sat_counter #(
      .WIDTH   (c_TMO_W),
      .MAX_VAL (TIMEOUT_CYC)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_grant_i | w_grant_d),
      .i_inc   (w_busy & ~m_ack),
      .o_count (w_tmo_cnt)
   );

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign m_req       = w_busy;
   assign m_we        = r_m_we;
   assign m_addr      = r_m_addr;
   assign m_wdata     = r_m_wdata;
   assign if_ack      = (r_state == ST_RESP) & ~r_grant_d;
   assign d_ack       = (r_state == ST_RESP) &  r_grant_d;
   assign if_rdata    = r_rdata;
   assign d_rdata     = r_rdata;
   assign timeout_err = r_timeout_err;
   assign stall_out   = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//            reference model predicts, from request timestamps and chosen
//            memory latencies, when m_req is high, what it carries, and when
//            each ack pulse and its read data appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;
   localparam int TMO  = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          stall_out;
   logic          timeout_err;

   int total = 0;
   int bad   = 0;

   // Reference model: one transfer described by grant kind, first BUSY cycle
   // s, BUSY length blen and the cycle the port is free to arbitrate again.
   int            cyc, nxt_idle, kind, s, blen, lat, streak;
   logic [AW-1:0] x_addr;
   logic          x_we;
   logic [DW-1:0] x_wdata, x_rdata;
   bit            x_tmo, terr;
   bit            prev_if_ack, prev_d_ack;
   int            p_if, p_d, fix_lat;
   bit            spur;
   // Observations from the DUT used by directed checks.
   bit            obs_if_ack, obs_d_ack;
   int            n_d_acks;
   int            last_d_at;
   logic [DW-1:0] last_d_rdata;
   int            t0, at, snap;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .MAX_D_STREAK (MAXS),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_ack      (if_ack),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_ack       (d_ack),
      .m_req       (m_req),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_ack       (m_ack),
      .stall_out   (stall_out),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: entered at posedge+1, drives inputs, predicts, checks at
   // the negedge, and returns at the next posedge+1.
   task automatic step();
      bit busy_now, ia, da;
      if (prev_if_ack) if_req = 1'b0;
      if (prev_d_ack)  d_req  = 1'b0;
      if (!if_req && ($urandom_range(99) < p_if)) begin
         if_req  = 1'b1;
         if_addr = $urandom;
      end
      if (!d_req && ($urandom_range(99) < p_d)) begin
         d_req   = 1'b1;
         d_we    = 1'($urandom_range(1));
         d_addr  = $urandom;
         d_wdata = $urandom;
      end

      busy_now = (kind != 0) && (cyc >= s) && (cyc < s + blen);
      ia       = (kind == 1) && (cyc == s + blen);
      da       = (kind == 2) && (cyc == s + blen);

      m_rdata = $urandom;
      m_ack   = 1'b0;
      if (busy_now && (cyc == s + lat)) begin
         m_ack   = 1'b1;
         x_rdata = m_rdata;
      end else if (!busy_now && spur) begin
         m_ack = 1'($urandom_range(1));
      end

      if (cyc == nxt_idle) begin
         if (if_req && (!d_req || streak == MAXS)) begin
            kind = 1; x_addr = if_addr; x_we = 1'b0; x_wdata = '0; streak = 0;
         end else if (d_req) begin
            kind = 2; x_addr = d_addr; x_we = d_we; x_wdata = d_wdata;
            streak = if_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
         end else begin
            kind = 0;
         end
         if (kind != 0) begin
            s = cyc + 1;
            if (fix_lat >= 0) lat = fix_lat;
            else if ($urandom_range(39) == 0) lat = TMO + 5;
            else lat = int'($urandom_range(3));
            x_tmo = (lat >= TMO);
            blen  = x_tmo ? TMO : lat + 1;
            if (x_tmo) x_rdata = 32'hDEAD_BEEF;
            nxt_idle = s + blen + 1;
         end else begin
            nxt_idle = cyc + 1;
         end
      end
      if ((ia || da) && x_tmo) terr = 1'b1;

      @(negedge clk);
      chk("m_req", m_req, busy_now);
      if (busy_now) begin
         chk("m_addr", m_addr, x_addr);
         chk("m_we", m_we, x_we);
         if (x_we) chk("m_wdata", m_wdata, x_wdata);
      end
      chk("if_ack", if_ack, ia);
      chk("d_ack", d_ack, da);
      if (ia) chk("if_rdata", if_rdata, x_rdata);
      if (da) chk("d_rdata", d_rdata, x_rdata);
      chk("stall_out", stall_out, (if_req & ~ia) | (d_req & ~da));
      chk("timeout_err", timeout_err, terr);

      obs_if_ack = if_ack;
      obs_d_ack  = d_ack;
      if (d_ack) begin
         n_d_acks++;
         last_d_at    = cyc;
         last_d_rdata = d_rdata;
      end
      prev_if_ack = ia;
      prev_d_ack  = da;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_until_ack(input bit want_d, input int budget, output int ack_at);
      ack_at = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (want_d ? obs_d_ack : obs_if_ack) begin
            ack_at = cyc - 1;
            break;
         end
      end
      total++;
      assert (ack_at >= 0) else begin
         bad++;
         $error("FAIL wait_ack: observed no ack within %0d cycles, expected an ack", budget);
      end
   endtask

   task automatic drain();
      p_if = 0;
      p_d  = 0;
      for (int i = 0; i < 200; i++) begin
         if (!if_req && !d_req && (cyc >= nxt_idle)) break;
         step();
      end
   endtask

   // Asserts reset mid-cycle, checks outputs clear at once, offers a late
   // m_ack while in reset, then releases and restarts the model.
   task automatic do_reset();
      rst    = 1'b0;
      if_req = 1'b0;
      d_req  = 1'b0;
      m_ack  = 1'b0;
      #1;
      chk("rst_m_req", m_req, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_if_ack", if_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_stall", stall_out, 0);
      m_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      m_ack = 1'b0;
      @(posedge clk);
      #1;
      cyc = 0; nxt_idle = 0; kind = 0; streak = 0; terr = 1'b0;
      prev_if_ack = 1'b0; prev_d_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack = 1'b0;
      p_if = 0; p_d = 0; fix_lat = 0; spur = 1'b0;
      n_d_acks = 0; last_d_at = -1; last_d_rdata = '0;
      cyc = 0; nxt_idle = 0; kind = 0; s = 0; blen = 0; lat = 0; streak = 0;
      x_tmo = 1'b0; terr = 1'b0; x_rdata = '0; x_addr = '0; x_we = 1'b0; x_wdata = '0;
      prev_if_ack = 1'b0; prev_d_ack = 1'b0; obs_if_ack = 1'b0; obs_d_ack = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Lone data write, memory answers in the first BUSY cycle.
      fix_lat = 0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234;
      t0 = cyc;
      run_until_ack(1'b1, 10, at);
      chk("lat_write", at - t0, 2);
      drain();

      // Fetch and data raised together: data first, fetch right after.
      fix_lat = 1;
      if_req = 1'b1; if_addr = 32'h0000_0400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
      t0 = cyc;
      run_until_ack(1'b0, 20, at);
      chk("both_d_lat", last_d_at - t0, 3);
      chk("both_if_lat", at - t0, 7);
      drain();

      // Continuous data traffic with a waiting fetch: four data grants, then
      // the fetch; the streak restarts so the pattern repeats.
      fix_lat = 0; p_d = 100; p_if = 100;
      snap = n_d_acks;
      run_until_ack(1'b0, 60, at);
      chk("streak_round1", n_d_acks - snap, MAXS);
      snap = n_d_acks;
      run_until_ack(1'b0, 60, at);
      chk("streak_round2", n_d_acks - snap, MAXS);
      drain();

      // Memory never answers: timeout after TMO BUSY cycles.
      fix_lat = 1000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      t0 = cyc;
      run_until_ack(1'b1, 100, at);
      chk("tmo_lat", at - t0, TMO + 1);
      chk("tmo_rdata", last_d_rdata, 32'hDEAD_BEEF);
      drain();
      fix_lat = 0;
      if_req = 1'b1; if_addr = 32'h0000_0800;
      run_until_ack(1'b0, 10, at);
      chk("tmo_sticky", timeout_err, 1);
      drain();

      // Randomized traffic with spurious m_ack outside BUSY.
      do_reset();
      spur = 1'b1; fix_lat = -1; p_if = 30; p_d = 45;
      repeat (600) step();
      drain();

      // Reset while a data transfer is in BUSY, then a late m_ack.
      spur = 1'b0; fix_lat = 20;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_00C0; d_wdata = 32'h5A5A_0001;
      step();
      step();
      chk("busy_before_rst", m_req, 1);
      snap = n_d_acks;
      do_reset();
      spur = 1'b1;
      repeat (8) step();
      chk("no_ack_after_rst", n_d_acks - snap, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
